// File: rtl/ean13_result_validator_pkg.sv
// rtl/ean13_result_validator_pkg.sv - shared constants, state encodings and mod-10 helpers
package ean13_result_validator_pkg;

  localparam int CODE_W = 52;
  localparam int DIGITS = 13;

  localparam logic [3:0] PARITY_ERR_NIBBLE = 4'hF;
  localparam logic [3:0] WEIGHT_ODD        = 4'd1;
  localparam logic [3:0] WEIGHT_EVEN       = 4'd3;

  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_CHECK = 3'b010;
  localparam logic [2:0] ST_VOTE  = 3'b100;

  // Digit positions are 1-based: odd positions weigh 1, even positions weigh 3.
  function automatic logic [3:0] digitWeight(input logic [3:0] pos);
    return pos[0] ? WEIGHT_ODD : WEIGHT_EVEN;
  endfunction

  function automatic logic [3:0] mod10Reduce(input logic [5:0] sum);
    logic [5:0] s;
    s = sum;
    for (int i = 0; i < 3; i++) begin
      if (s >= 6'd10) s = s - 6'd10;
    end
    return s[3:0];
  endfunction

endpackage

// File: rtl/ean13_result_validator_check_digit.sv
// rtl/ean13_result_validator_check_digit.sv - serial EAN-13 check-digit sequencer
// Walks the 13 nibbles MSB first, one per cycle, then presents done/valid for one VOTE cycle.
module ean13_check_digit
  import ean13_result_validator_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [CODE_W-1:0] iCode,
  output logic              oIdle,
  output logic              oDone,
  output logic              oValid,
  output logic [CODE_W-1:0] oCode
);

  logic [2:0]        state;
  logic [CODE_W-1:0] shiftReg;
  logic [CODE_W-1:0] codeReg;
  logic [3:0]        acc;
  logic [3:0]        digitIdx;
  logic              errFlag;
  logic              validReg;

  logic [3:0] nibble;
  logic [3:0] pos;
  logic [5:0] product;
  logic [3:0] accNext;
  logic [3:0] expected;
  logic       digitBad;

  always_comb begin
    nibble   = shiftReg[CODE_W-1 -: 4];
    pos      = digitIdx + 4'd1;
    product  = {2'b00, digitWeight(pos)} * {2'b00, nibble};
    accNext  = mod10Reduce({2'b00, acc} + product);
    expected = (acc == 4'd0) ? 4'd0 : 4'd10 - acc;
    digitBad = nibble > 4'd9;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= ST_IDLE;
      shiftReg <= '0;
      codeReg  <= '0;
      acc      <= '0;
      digitIdx <= '0;
      errFlag  <= 1'b0;
      validReg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            shiftReg <= iCode;
            codeReg  <= iCode;
            acc      <= '0;
            digitIdx <= '0;
            errFlag  <= iCode[CODE_W-1 -: 4] == PARITY_ERR_NIBBLE;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          shiftReg <= {shiftReg[CODE_W-5:0], 4'h0};
          errFlag  <= errFlag | digitBad;
          if (digitIdx == 4'(DIGITS - 1)) begin
            validReg <= !(errFlag | digitBad) && (nibble == expected);
            state    <= ST_VOTE;
          end else begin
            acc      <= accNext;
            digitIdx <= digitIdx + 4'd1;
          end
        end
        ST_VOTE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oIdle  = state == ST_IDLE;
  assign oDone  = state == ST_VOTE;
  assign oValid = validReg;
  assign oCode  = codeReg;

endmodule

// File: rtl/ean13_result_validator.sv
// rtl/ean13_result_validator.sv - votes raw scanner lines into confirmed, de-duplicated EAN-13 reports
module ean13_result_validator
  import ean13_result_validator_pkg::*;
#(
  parameter  int V_TOTAL            = 24,
  parameter  int REQUIRED_MATCHES   = 3,
  parameter  int MAX_LINE_GAP       = 4,
  parameter  int REPORT_HOLD_FRAMES = 2,
  localparam int VPIX_W             = $clog2(V_TOTAL) + 1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iNewData,
  input  logic [CODE_W-1:0] iDataCode,
  input  logic [VPIX_W-1:0] iVpixel,
  output logic [CODE_W-1:0] oCode,
  output logic              oCodeValid,
  input  logic              iCodeReady,
  output logic              oChecksumErr,
  output logic              oDropped
);

  localparam logic [3:0] REQ  = 4'(REQUIRED_MATCHES);
  localparam logic [3:0] GAP  = 4'(MAX_LINE_GAP);
  localparam logic [3:0] HOLD = 4'(REPORT_HOLD_FRAMES);

  logic              chkIdle;
  logic              chkDone;
  logic              chkValid;
  logic [CODE_W-1:0] chkCode;

  logic [CODE_W-1:0] candidate;
  logic [CODE_W-1:0] lastReported;
  logic [3:0]        matchCount;
  logic [3:0]        gapCount;
  logic [3:0]        holdCount;
  logic [VPIX_W-1:0] prevVpixel;
  logic              validSeen;

  logic              startChk;
  logic              rawDrop;
  logic              lineBoundary;
  logic              frameBoundary;
  logic              voteValid;
  logic              voteBad;
  logic              sameCode;
  logic [3:0]        prevEff;
  logic [3:0]        countVote;
  logic [3:0]        gapInc;
  logic              fire;
  logic              suppress;
  logic              canLoad;
  logic              loadOut;
  logic              lostConfirm;
  logic [3:0]        holdBase;

  logic [CODE_W-1:0] candNext;
  logic [3:0]        countNext;
  logic [3:0]        gapNext;
  logic              seenNext;
  logic [3:0]        holdNext;

  ean13_check_digit uCheck (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (startChk),
    .iCode  (iDataCode),
    .oIdle  (chkIdle),
    .oDone  (chkDone),
    .oValid (chkValid),
    .oCode  (chkCode)
  );

  always_comb begin
    startChk      = iNewData && chkIdle;
    rawDrop       = iNewData && !chkIdle;
    lineBoundary  = iVpixel != prevVpixel;
    frameBoundary = lineBoundary && (iVpixel == '0);
    voteValid     = chkDone && chkValid;
    voteBad       = chkDone && !chkValid;
    sameCode      = chkCode == candidate;
    // A new candidate starts its run from zero, so a single-match config still fires on a switch.
    prevEff       = sameCode ? matchCount : 4'd0;
    countVote     = !sameCode ? 4'd1 : (matchCount >= REQ) ? REQ : matchCount + 4'd1;
    gapInc        = (gapCount == 4'hF) ? gapCount : gapCount + 4'd1;
    fire          = voteValid && (countVote == REQ) && (prevEff < REQ);
    suppress      = (chkCode == lastReported) && (holdCount != 4'd0);
    canLoad       = !oCodeValid || iCodeReady;
    loadOut       = fire && !suppress && canLoad;
    lostConfirm   = fire && !suppress && !canLoad;
    holdBase      = loadOut ? HOLD : holdCount;
  end

  always_comb begin
    candNext  = candidate;
    countNext = matchCount;
    gapNext   = gapCount;
    seenNext  = validSeen;
    holdNext  = holdBase;
    if (voteValid) begin
      candNext  = chkCode;
      countNext = countVote;
      gapNext   = 4'd0;
      seenNext  = 1'b1;
    end
    // A valid result landing on the boundary cycle still credits the line that just ended.
    if (lineBoundary) begin
      if (!validSeen && !voteValid) begin
        gapNext = gapInc;
        if (gapInc >= GAP) countNext = 4'd0;
      end
      seenNext = 1'b0;
    end
    if (frameBoundary) begin
      candNext  = '0;
      countNext = 4'd0;
      gapNext   = 4'd0;
      holdNext  = (holdBase == 4'd0) ? 4'd0 : holdBase - 4'd1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oCode        <= '0;
      oCodeValid   <= 1'b0;
      oChecksumErr <= 1'b0;
      oDropped     <= 1'b0;
      candidate    <= '0;
      matchCount   <= '0;
      gapCount     <= '0;
      lastReported <= '0;
      holdCount    <= '0;
      prevVpixel   <= '0;
      validSeen    <= 1'b0;
    end else begin
      prevVpixel   <= iVpixel;
      oChecksumErr <= voteBad;
      oDropped     <= rawDrop || lostConfirm;
      candidate    <= candNext;
      matchCount   <= countNext;
      gapCount     <= gapNext;
      validSeen    <= seenNext;
      holdCount    <= holdNext;
      if (loadOut) begin
        oCode        <= chkCode;
        oCodeValid   <= 1'b1;
        lastReported <= chkCode;
      end else if (oCodeValid && iCodeReady) begin
        oCodeValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ean13_result_validator.sv
// tb/tb_ean13_result_validator.sv - scoreboard bench for ean13_result_validator
module tb_ean13_result_validator;

  localparam int VPIX_W   = $clog2(24) + 1;
  localparam int LINE_LEN = 40;

  localparam logic [51:0] CODE_A   = 52'h5901234123457;
  localparam logic [51:0] CODE_B   = 52'h4006381333931;
  localparam logic [51:0] CODE_BAD = 52'h5901234123458;
  localparam logic [51:0] CODE_PAR = 52'hF901234123457;

  logic              iClk       = 1'b0;
  logic              iRst       = 1'b1;
  logic              iNewData   = 1'b0;
  logic [51:0]       iDataCode  = '0;
  logic [VPIX_W-1:0] iVpixel    = '0;
  logic              iCodeReady = 1'b1;
  logic [51:0]       oCode;
  logic              oCodeValid;
  logic              oChecksumErr;
  logic              oDropped;

  ean13_result_validator #(
    .V_TOTAL            (24),
    .REQUIRED_MATCHES   (3),
    .MAX_LINE_GAP       (4),
    .REPORT_HOLD_FRAMES (2)
  ) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iNewData     (iNewData),
    .iDataCode    (iDataCode),
    .iVpixel      (iVpixel),
    .oCode        (oCode),
    .oCodeValid   (oCodeValid),
    .iCodeReady   (iCodeReady),
    .oChecksumErr (oChecksumErr),
    .oDropped     (oDropped)
  );

  always #5 iClk = ~iClk;

  int          cyc = 0;
  int          nChecks = 0;
  int          nErrors = 0;
  int          errPulses = 0;
  int          dropPulses = 0;
  int          lastNdCyc = 0;
  int          riseCyc = 0;
  logic        prevValid = 1'b0;
  logic [51:0] expQ[$];

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every accepted report must match the oldest expected code.
  always @(negedge iClk) begin
    if (!iRst) begin
      if (oChecksumErr) errPulses++;
      if (oDropped) dropPulses++;
      if (oCodeValid && !prevValid) riseCyc = cyc;
      if (oCodeValid && iCodeReady) begin
        check("report_expected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) check("report_code", 64'(oCode), 64'(expQ.pop_front()));
      end
    end
    prevValid = oCodeValid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic pulseData(input logic [51:0] code);
    iNewData  = 1'b1;
    iDataCode = code;
    lastNdCyc = cyc;
    tick(1);
    iNewData  = 1'b0;
  endtask

  task automatic sendLine(input logic [51:0] code, input bit hasData, input int dly,
                          input logic [51:0] code2);
    int used;
    iVpixel = iVpixel + VPIX_W'(1);
    tick(2);
    used = 2;
    if (hasData) begin
      pulseData(code);
      used++;
      if (dly > 0) begin
        tick(dly - 1);
        pulseData(code2);
        used += dly;
      end
    end
    tick(LINE_LEN - used);
  endtask

  task automatic newFrame();
    if (iVpixel == '0) begin
      iVpixel = VPIX_W'(1);
      tick(4);
    end
    iVpixel = '0;
    tick(4);
  endtask

  task automatic settle();
    repeat (3) newFrame();
    errPulses  = 0;
    dropPulses = 0;
  endtask

  task automatic testEnd(input string tag, input int expErr, input int expDrop);
    tick(4);
    check({tag, "_chkerr"}, 64'(errPulses), 64'(expErr));
    check({tag, "_dropped"}, 64'(dropPulses), 64'(expDrop));
    check({tag, "_pending"}, 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    tick(3);
    check("rst_code", 64'(oCode), 64'd0);
    check("rst_valid", 64'(oCodeValid), 64'd0);
    check("rst_chkerr", 64'(oChecksumErr), 64'd0);
    check("rst_dropped", 64'(oDropped), 64'd0);
    iRst = 1'b0;
    tick(2);

    settle();
    expQ.push_back(CODE_A);
    repeat (3) sendLine(CODE_A, 1, 0, '0);
    check("latency", 64'(riseCyc - lastNdCyc), 64'd15);
    testEnd("valid", 0, 0);

    settle();
    repeat (3) sendLine(CODE_BAD, 1, 0, '0);
    sendLine(CODE_PAR, 1, 0, '0);
    check("bad_valid", 64'(oCodeValid), 64'd0);
    testEnd("bad", 4, 0);

    settle();
    expQ.push_back(CODE_B);
    repeat (2) sendLine(CODE_A, 1, 0, '0);
    repeat (3) sendLine(CODE_B, 1, 0, '0);
    testEnd("switch", 0, 0);

    settle();
    repeat (2) sendLine(CODE_A, 1, 0, '0);
    repeat (4) sendLine('0, 0, 0, '0);
    sendLine(CODE_A, 1, 0, '0);
    testEnd("gap", 0, 0);

    settle();
    repeat (2) sendLine(CODE_A, 1, 0, '0);
    newFrame();
    sendLine(CODE_A, 1, 0, '0);
    testEnd("frame", 0, 0);

    settle();
    iCodeReady = 1'b0;
    expQ.push_back(CODE_A);
    repeat (3) sendLine(CODE_A, 1, 0, '0);
    repeat (3) sendLine(CODE_B, 1, 0, '0);
    check("bp_valid", 64'(oCodeValid), 64'd1);
    check("bp_code_held", 64'(oCode), 64'(CODE_A));
    iCodeReady = 1'b1;
    tick(1);
    iCodeReady = 1'b0;
    check("bp_valid_cleared", 64'(oCodeValid), 64'd0);
    iCodeReady = 1'b1;
    testEnd("bp", 0, 1);

    settle();
    expQ.push_back(CODE_A);
    repeat (3) sendLine(CODE_A, 1, 0, '0);
    newFrame();
    expQ.push_back(CODE_A);
    repeat (3) sendLine(CODE_A, 1, 0, '0);
    check("hold_suppressed", 64'(expQ.size()), 64'd1);
    newFrame();
    repeat (3) sendLine(CODE_A, 1, 0, '0);
    testEnd("hold", 0, 0);

    settle();
    expQ.push_back(CODE_A);
    repeat (2) sendLine(CODE_A, 1, 0, '0);
    sendLine(CODE_A, 1, 5, CODE_B);
    testEnd("overlap", 0, 1);

    settle();
    iCodeReady = 1'b0;
    repeat (3) sendLine(CODE_A, 1, 0, '0);
    check("pre_rst_valid", 64'(oCodeValid), 64'd1);
    iVpixel = iVpixel + VPIX_W'(1);
    tick(2);
    pulseData(CODE_B);
    tick(5);
    iRst = 1'b1;
    tick(1);
    check("midrst_code", 64'(oCode), 64'd0);
    check("midrst_valid", 64'(oCodeValid), 64'd0);
    check("midrst_chkerr", 64'(oChecksumErr), 64'd0);
    check("midrst_dropped", 64'(oDropped), 64'd0);
    iRst       = 1'b0;
    iCodeReady = 1'b1;
    errPulses  = 0;
    dropPulses = 0;
    tick(2);
    expQ.push_back(CODE_A);
    repeat (3) sendLine(CODE_A, 1, 0, '0);
    testEnd("reset", 0, 0);

    tick(5);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/ean13_result_validator.md
Name: ean13_result_validator

Overview:
Sits downstream of the EAN-13 line scanner and sequences its per-line raw results into confirmed barcode reports. Each raw 13-digit code is checked digit by digit by an internal check-digit FSM. The block then requires REQUIRED_MATCHES agreeing lines within a frame before confirming a code. Confirmed codes go to the display/UART consumer over a valid/ready handshake, with duplicate suppression across frames.

Parameters:
V_TOTAL, 24, total lines per frame; sets VPIX_W = clog2(V_TOTAL)+1, the width of iVpixel.
REQUIRED_MATCHES, 3, consecutive identical valid lines needed to confirm; range 1..15.
MAX_LINE_GAP, 4, lines allowed without a valid result before the vote resets; range 1..15.
REPORT_HOLD_FRAMES, 2, frames during which a re-confirmed identical code is not re-reported; range 0..15.

Ports:
iClk  in  1  clock.
iRst  in  1  asynchronous, active-high reset.
iNewData  in  1  one-cycle pulse from scanner: iDataCode valid.
iDataCode  in  52  [51:48] = first digit (0xF = parity error), [47:0] = digits 2..13, MSB first.
iVpixel  in  VPIX_W  current scanner line number.
oCode  out  52  confirmed code; stable while oCodeValid.
oCodeValid  out  1  confirmed code pending.
iCodeReady  in  1  consumer accepts when high with oCodeValid.
oChecksumErr  out  1  one-cycle pulse per rejected raw code.
oDropped  out  1  one-cycle pulse when raw or confirmed data is lost.

Behaviour:
- Reset values: oCode=0, oCodeValid=0, oChecksumErr=0, oDropped=0, FSM=IDLE, candidate=0, matchCount=0, gapCount=0, lastReported=0, holdCount=0.
- FSM states and transitions:
  - IDLE: on iNewData, latch iDataCode into a shift register, clear acc and the digit index, go to CHECK.
  - CHECK: 13 cycles, one nibble per cycle, MSB nibble first (digit position p = 1..13).
    - Any nibble > 9 sets an error flag.
    - For p = 1..12: acc = (acc + w*d) mod 10, with w = 1 for odd p and w = 3 for even p. Acc is 4 bits; the intermediate sum is at most 36, so the reduction subtracts 10 up to 3 times, combinationally.
    - At p = 13, compute expected = (10 - acc) mod 10. The code is valid iff no error flag and d13 == expected.
    - After the 13th cycle go to VOTE.
  - VOTE (1 cycle):
    - If invalid: pulse oChecksumErr; candidate and matchCount are untouched.
    - If valid and code == candidate: matchCount++ (saturates at REQUIRED_MATCHES).
    - If valid and code differs: candidate = code, matchCount = 1.
    - If valid: gapCount = 0.
    - Confirmation fires when the updated matchCount == REQUIRED_MATCHES and the previous value was lower, i.e. it fires once per run.
    - Go to IDLE.
- Latency: iNewData at cycle T gives CHECK on T+1..T+13, VOTE on T+14, and oCodeValid high at T+15 if confirmed.
- Dropping raw codes: iNewData while the FSM is not IDLE is discarded and oDropped pulses. The line period exceeds 15 cycles, so this only happens on abnormal input.
- Confirmation output:
  - If code == lastReported and holdCount != 0: suppress, no output.
  - Else, if oCodeValid==0 or (oCodeValid && iCodeReady) in that cycle: load oCode, set oCodeValid, lastReported = code, holdCount = REPORT_HOLD_FRAMES.
  - Else (output still pending): keep the old oCode and pulse oDropped.
- Handshake: oCodeValid clears on the cycle after oCodeValid && iCodeReady unless a new confirmation loads in that same cycle. oCode never changes while oCodeValid && !iCodeReady.
- Line tracking: a change of iVpixel is a line boundary.
  - At each line boundary with no valid result since the last one, gapCount++ (saturating).
  - When gapCount reaches MAX_LINE_GAP: matchCount = 0.
- Frame boundary (iVpixel changes to 0):
  - matchCount = 0, candidate = 0, gapCount = 0.
  - holdCount decrements, saturating at 0; lastReported is kept.
  - A frame boundary in the same cycle as VOTE: the VOTE update applies first and the frame clear wins.
- Reset mid-CHECK or with output pending: everything returns to reset values; the pending code is lost and oDropped does not pulse.

Decomposition:
- Shared package/include: EAN digit weights, the 0xF parity-error nibble constant, and FSM state encodings (one-hot, 3 bits).
- One natural sub-module: ean13_check_digit. It holds the CHECK sequencer and mod-10 accumulator, with a start/code in and done/valid out. The vote, handshake and hold logic stay in the top.

Test Plan:
- Valid code: 3 lines of iDataCode=0x5901234123457, one per line, in one frame -> no oChecksumErr; oCodeValid rises 15 cycles after the 3rd iNewData; oCode=0x5901234123457.
- Bad checksum: 0x5901234123458 ×3 -> 3 oChecksumErr pulses, oCodeValid stays 0. Parity error 0xF901234123457 -> rejected with oChecksumErr.
- Vote reset:
  - A,A,B,B,B -> confirms B only.
  - A,A, then 4 lines with no result, then A -> no confirmation (gap reset).
  - A,A, frame boundary, A -> no confirmation.
- Backpressure: iCodeReady=0, confirm A, then confirm B in the same frame -> oCode holds A, oDropped pulses once. Raising iCodeReady for 1 cycle drops oCodeValid the next cycle.
- Hold: confirm A (accepted), next frame A confirmed again -> suppressed. After 2 frame boundaries, A again -> reported.
- Overlap and reset: iNewData 5 cycles after the previous one -> oDropped pulse, first code still voted. Assert iRst during CHECK -> all outputs 0 on the next cycle; a subsequent valid run confirms normally.
